// File: rtl/ras_pkg.sv
// Shared sizing constants for the return-address stack.
package ras_pkg;
  localparam int RAS_DEPTH      = 8;
  localparam int RAS_DATA_WIDTH = 32;
  localparam int RAS_PTR_WIDTH  = $clog2(RAS_DEPTH);
endpackage

// File: rtl/ras_storage.sv
// Return-address register file: one synchronous write port, one asynchronous read port.
module ras_storage
  import ras_pkg::*;
#(
  parameter int DEPTH      = RAS_DEPTH,
  parameter int DATA_WIDTH = RAS_DATA_WIDTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [PTR_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     mem_q          <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_address_stack.sv
// Circular LIFO of link addresses for IF: jal/jalr push PC+4, jr $ra pops the predicted target.
module return_address_stack
  import ras_pkg::*;
#(
  parameter int DEPTH      = RAS_DEPTH,
  parameter int DATA_WIDTH = RAS_DATA_WIDTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  push_en,
  input  logic [DATA_WIDTH-1:0] push_addr,
  input  logic                  pop_en,
  output logic [DATA_WIDTH-1:0] top_addr,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] TOS_RST  = PTR_WIDTH'(DEPTH-1);

  logic [PTR_WIDTH-1:0]  tos_q, tos_d, tos_inc, waddr;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, we;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign tos_inc  = tos_q + PTR_WIDTH'(1);

  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = 1'b0;
    we      = 1'b0;
    waddr   = tos_inc;
    if (flush) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (!stall) begin
      if (push_en && pop_en && !is_empty) begin
        // call+return in one fetch: replace the top in place
        we    = 1'b1;
        waddr = tos_q;
      end else if (push_en) begin
        // a push while full silently overwrites the oldest slot via pointer wrap
        we    = 1'b1;
        tos_d = tos_inc;
        if (is_full) ovf_d   = 1'b1;
        else         count_d = count_q + (PTR_WIDTH+1)'(1);
      end else if (pop_en) begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          tos_d   = tos_q - PTR_WIDTH'(1);
          count_d = count_q - (PTR_WIDTH+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tos_q   <= TOS_RST;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  ras_storage #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_storage (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (push_addr),
    .raddr_i (tos_q),
    .rdata_o (rd_data)
  );

  assign top_addr  = is_empty ? '0 : rd_data;
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
